clut_map_reader: RTL

- Producer side of the clutter-map threshold stream.
- On a start pulse for CPI index c, reads three clutter-map planes from three parallel map-RAM read ports: c-1 (prev), c (cur) and c+1 (next).
- Emits the three planes as one gap-free, lock-stepped stream (radmap_rd_vld, radmap_rd_din1/2/3) to the downstream 3x3 max-threshold stage.
- That stage aligns neighbours with fixed ROW_LEN-cycle delays, so the stream must have no gaps.

---
 rtl/clut_map_pkg.sv | 20 ++
 rtl/clut_map_reader_align.sv | 47 ++++
 rtl/clut_map_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clut_map_pkg.sv
// Shared constants and FSM state type for the clutter-map stream reader.
// Optional build macro: CLUT_RD_EDGE_ZERO_EN (see clut_map_reader).
package clut_map_pkg;

  localparam int unsigned DEF_ROW_LEN = 32;
  localparam int unsigned DEF_N_ROW   = 64;
  localparam int unsigned DEF_N_CPI   = 120;
  localparam int unsigned DEF_RAM_LAT = 2;
  localparam int unsigned DEF_AW      = 18;
  localparam int unsigned PLANE_WORDS = DEF_N_ROW * DEF_ROW_LEN;
  localparam int unsigned MAP_DW      = 16;
  localparam int unsigned N_LANES     = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/clut_map_reader_align.sv
// Read-latency alignment for the three map lanes: delays the per-lane read enables
// and registers each lane's RAM word on the cycle it is valid, zero otherwise.
module clut_rd_align
  import clut_map_pkg::*;
#(
  parameter int unsigned LAT   = DEF_RAM_LAT,
  parameter int unsigned DW    = MAP_DW,
  parameter int unsigned LANES = N_LANES
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [LANES-1:0]           rd_en,
  input  logic [LANES-1:0][DW-1:0]   rd_data,
  output logic                       vld,
  output logic [LANES-1:0][DW-1:0]   dout,
  output logic                       pending
);

  logic [LANES-1:0]         en_sr_q [LAT];
  logic                     vld_q;
  logic [LANES-1:0][DW-1:0] dout_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) en_sr_q[i] <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      en_sr_q[0] <= rd_en;
      for (int unsigned i = 1; i < LAT; i++) en_sr_q[i] <= en_sr_q[i-1];
      vld_q <= |en_sr_q[LAT-1];
      // A lane whose enable was masked contributes zero even while the stream is valid.
      for (int unsigned l = 0; l < LANES; l++) begin
        dout_q[l] <= en_sr_q[LAT-1][l] ? rd_data[l] : '0;
      end
    end
  end

  always_comb begin
    pending = vld_q;
    for (int unsigned i = 0; i < LAT; i++) pending = pending | (|en_sr_q[i]);
  end

  assign vld  = vld_q;
  assign dout = dout_q;

endmodule

// File: rtl/clut_map_reader.sv
// Clutter-map plane reader: streams planes c-1, c, c+1 gap-free and lock-stepped.
// Build macro CLUT_RD_EDGE_ZERO_EN: no plane wrap; edge neighbours are masked and zeroed.
module clut_map_reader
  import clut_map_pkg::*;
#(
  parameter int unsigned ROW_LEN = DEF_ROW_LEN,
  parameter int unsigned N_ROW   = DEF_N_ROW,
  parameter int unsigned N_CPI   = DEF_N_CPI,
  parameter int unsigned RAM_LAT = DEF_RAM_LAT,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned FLUSH   = 2 * ROW_LEN
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   clut_cpi,
  output logic          busy,
  output logic          done,
  output logic          start_err,
  output logic          map_rd_en,
  output logic [AW-1:0] map_rd_addr1,
  output logic [AW-1:0] map_rd_addr2,
  output logic [AW-1:0] map_rd_addr3,
  input  logic [15:0]   map_rd_data1,
  input  logic [15:0]   map_rd_data2,
  input  logic [15:0]   map_rd_data3,
  output logic          radmap_rd_vld,
  output logic [15:0]   radmap_rd_din1,
  output logic [15:0]   radmap_rd_din2,
  output logic [15:0]   radmap_rd_din3
);

  localparam int unsigned PlaneWords = N_ROW * ROW_LEN;
  localparam int unsigned KW         = (PlaneWords > 1) ? $clog2(PlaneWords) : 1;
  localparam int unsigned FW         = $clog2(FLUSH + 1);
  localparam logic [KW-1:0] KLast    = KW'(PlaneWords - 1);
  localparam logic [FW-1:0] FLast    = FW'(FLUSH - 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [FW-1:0]  flush_q, flush_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           load;
  logic           pipe_pending;

  logic [AW-1:0]  addr1_q, addr2_q, addr3_q;
  logic [2:0]     lane_en_q;
  logic [2:0]     lane_mask;
  logic [2:0]     rd_en_vec;
  logic           cpi_ok;
  logic [15:0]    prev_cpi, next_cpi;

  logic [N_LANES-1:0][MAP_DW-1:0] rd_data, dout;

  // Constant multiply, evaluated only when a request is accepted.
  function automatic logic [AW-1:0] plane_base(input logic [15:0] cpi);
    return AW'((32'(cpi) - 32'd1) * PlaneWords);
  endfunction

  always_comb begin
    cpi_ok   = (clut_cpi != 16'd0) && (32'(clut_cpi) <= N_CPI);
    prev_cpi = (clut_cpi == 16'd1) ? 16'(N_CPI) : clut_cpi - 16'd1;
    next_cpi = (32'(clut_cpi) == N_CPI) ? 16'd1 : clut_cpi + 16'd1;
`ifdef CLUT_RD_EDGE_ZERO_EN
    lane_mask = {32'(clut_cpi) != N_CPI, 1'b1, clut_cpi != 16'd1};
`else
    lane_mask = 3'b111;
`endif
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flush_d = flush_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cpi_ok) begin
            state_d = StRun;
            busy_d  = 1'b1;
            k_d     = '0;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          k_d     = '0;
          flush_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        // Flush count only starts once the last valid word has left the pipe.
        if (pipe_pending) begin
          flush_d = '0;
        end else if (flush_q == FLast) begin
          state_d = StIdle;
          flush_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr1_q   <= '0;
      addr2_q   <= '0;
      addr3_q   <= '0;
      lane_en_q <= '0;
    end else if (load) begin
      addr1_q   <= plane_base(prev_cpi);
      addr2_q   <= plane_base(clut_cpi);
      addr3_q   <= plane_base(next_cpi);
      lane_en_q <= lane_mask;
    end else if (state_q == StRun) begin
      if (k_q == KLast) begin
        addr1_q <= '0;
        addr2_q <= '0;
        addr3_q <= '0;
      end else begin
        addr1_q <= addr1_q + 1'b1;
        addr2_q <= addr2_q + 1'b1;
        addr3_q <= addr3_q + 1'b1;
      end
    end
  end

  assign rd_en_vec    = lane_en_q & {3{state_q == StRun}};
  assign map_rd_en    = |rd_en_vec;
  assign map_rd_addr1 = addr1_q;
  assign map_rd_addr2 = addr2_q;
  assign map_rd_addr3 = addr3_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign start_err    = err_q;
  assign rd_data      = {map_rd_data3, map_rd_data2, map_rd_data1};

  clut_rd_align #(
    .LAT   (RAM_LAT),
    .DW    (MAP_DW),
    .LANES (N_LANES)
  ) u_align (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en_vec),
    .rd_data (rd_data),
    .vld     (radmap_rd_vld),
    .dout    (dout),
    .pending (pipe_pending)
  );

  assign radmap_rd_din1 = dout[0];
  assign radmap_rd_din2 = dout[1];
  assign radmap_rd_din3 = dout[2];

endmodule
